// File: rtl/mc_control.sv
// Multi-cycle CPU control FSM: 3-5 cycles per instruction, Moore outputs from the state register.
// Backpressure: mem_ready low holds FETCH/MEMRD/MEMWR with strobes steady and commit enables low.
module mc_control #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010,
   parameter logic [5:0] OP_ADDI  = 6'b001000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
      BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11
   } state_t;

   state_t st_q, st_d;
   logic   run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q <= FETCH;
         run  <= 1'b0;
      end else begin
         st_q <= st_d;
         run  <= 1'b1;
      end
   end

   assign state = st_q;

   // Everything stays at zero and the FSM is frozen until run is set.
   always_comb begin
      st_d          = st_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      if (run) begin
         case (st_q)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               if (mem_ready) st_d = DECODE;
            end
            DECODE: begin
               alu_src_b = 2'b11;
               if (opcode == OP_LW || opcode == OP_SW) st_d = MEMADR;
               else if (opcode == OP_RTYPE)            st_d = EXEC;
               else if (opcode == OP_BEQ)              st_d = BRANCH;
               else if (opcode == OP_J)                st_d = JUMP;
               else if (opcode == OP_ADDI)             st_d = ADDIEX;
               else begin
                  st_d       = FETCH;
                  illegal_op = 1'b1;
               end
            end
            MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               st_d      = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
               if (mem_ready) st_d = MEMWB;
            end
            MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               instr_done = 1'b1;
               st_d       = FETCH;
            end
            MEMWR: begin
               mem_write  = 1'b1;
               iord       = 1'b1;
               instr_done = mem_ready;
               if (mem_ready) st_d = FETCH;
            end
            EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
               st_d      = ALUWB;
            end
            ALUWB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               instr_done = 1'b1;
               st_d       = FETCH;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               instr_done    = 1'b1;
               st_d          = FETCH;
            end
            JUMP: begin
               pc_write   = 1'b1;
               pc_source  = 2'b10;
               instr_done = 1'b1;
               st_d       = FETCH;
            end
            ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               st_d      = ADDIWB;
            end
            ADDIWB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               st_d       = FETCH;
            end
            default: st_d = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Directed per-cycle vectors for mc_control plus a mid-store reset sequence.
module tb_mc_control;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   // Control word: pcw pcwc iord mrd mwr irw m2r rdst rw asa | asb | aop | psrc | done ill
   localparam logic [17:0] W_IDLE    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] W_FETCH_R = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] W_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] W_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
   localparam logic [17:0] W_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
   localparam logic [17:0] W_ADR     = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
   localparam logic [17:0] W_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] W_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
   localparam logic [17:0] W_MEMWR_W = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] W_MEMWR_R = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
   localparam logic [17:0] W_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
   localparam logic [17:0] W_ALUWB   = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
   localparam logic [17:0] W_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
   localparam logic [17:0] W_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
   localparam logic [17:0] W_ADDIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;

   typedef struct {
      logic       rst_n;
      logic [5:0] op;
      logic       rdy;
      logic [3:0] st;
      logic [17:0] w;
   } vec_t;

   logic       clk;
   logic       rst_n = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;
   logic [17:0] ctl_word;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   vec_t tbl[$];

   mc_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
      .state(state)
   );

   assign ctl_word = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, instr_done, illegal_op};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (instr_done === 1'b1) n_done++;

   task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [17:0] w);
      vec_t v;
      v.rst_n = r; v.op = op; v.rdy = rdy; v.st = st; v.w = w;
      tbl.push_back(v);
   endtask

   // Drive one cycle's inputs, check Moore outputs mid-cycle, then cross the edge.
   task automatic run_vec(input vec_t v, input int idx);
      rst_n = v.rst_n; opcode = v.op; mem_ready = v.rdy;
      #1;
      check("state", idx, {28'd0, state}, {28'd0, v.st});
      check("ctl", idx, {14'd0, ctl_word}, {14'd0, v.w});
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset held 3 cycles, then the run-flag idle cycle (mem_ready=1 must not leak).
      add(0, OP_LW, 0, 4'd0, W_IDLE);
      add(0, OP_LW, 1, 4'd0, W_IDLE);
      add(0, OP_LW, 0, 4'd0, W_IDLE);
      add(1, OP_LW, 1, 4'd0, W_IDLE);
      // LW: 2 fetch waits, 3 read waits
      add(1, OP_LW, 0, 4'd0, W_FETCH_W);
      add(1, OP_LW, 0, 4'd0, W_FETCH_W);
      add(1, OP_LW, 1, 4'd0, W_FETCH_R);
      add(1, OP_LW, 0, 4'd1, W_DECODE);
      add(1, OP_LW, 0, 4'd2, W_ADR);
      add(1, OP_LW, 0, 4'd3, W_MEMRD);
      add(1, OP_LW, 0, 4'd3, W_MEMRD);
      add(1, OP_LW, 0, 4'd3, W_MEMRD);
      add(1, OP_LW, 1, 4'd3, W_MEMRD);
      add(1, OP_LW, 0, 4'd4, W_MEMWB);
      // R-type then ADDI
      add(1, OP_RTYPE, 1, 4'd0, W_FETCH_R);
      add(1, OP_RTYPE, 1, 4'd1, W_DECODE);
      add(1, OP_RTYPE, 1, 4'd6, W_EXEC);
      add(1, OP_RTYPE, 1, 4'd7, W_ALUWB);
      add(1, OP_ADDI, 1, 4'd0, W_FETCH_R);
      add(1, OP_ADDI, 1, 4'd1, W_DECODE);
      add(1, OP_ADDI, 1, 4'd10, W_ADR);
      add(1, OP_ADDI, 1, 4'd11, W_ADDIWB);
      // BEQ then J
      add(1, OP_BEQ, 1, 4'd0, W_FETCH_R);
      add(1, OP_BEQ, 1, 4'd1, W_DECODE);
      add(1, OP_BEQ, 1, 4'd8, W_BRANCH);
      add(1, OP_J, 1, 4'd0, W_FETCH_R);
      add(1, OP_J, 1, 4'd1, W_DECODE);
      add(1, OP_J, 1, 4'd9, W_JUMP);
      // Illegal opcode
      add(1, OP_BAD, 1, 4'd0, W_FETCH_R);
      add(1, OP_BAD, 1, 4'd1, W_DEC_ILL);
      // SW with one write wait; opcode changes in MEMWR must be ignored
      add(1, OP_SW, 1, 4'd0, W_FETCH_R);
      add(1, OP_SW, 1, 4'd1, W_DECODE);
      add(1, OP_SW, 0, 4'd2, W_ADR);
      add(1, OP_LW, 0, 4'd5, W_MEMWR_W);
      add(1, OP_LW, 1, 4'd5, W_MEMWR_R);
      add(1, OP_SW, 0, 4'd0, W_FETCH_W);

      #2;
      rst_n = 1'b0;
      foreach (tbl[i]) run_vec(tbl[i], i);
      check("done_count_table", 100, n_done, 6);

      // Store aborted by reset while stalled in MEMWR.
      run_vec('{1'b1, OP_SW, 1'b1, 4'd0, W_FETCH_R}, 200);
      run_vec('{1'b1, OP_SW, 1'b0, 4'd1, W_DECODE}, 201);
      run_vec('{1'b1, OP_SW, 1'b0, 4'd2, W_ADR}, 202);
      mem_ready = 1'b0;
      #1;
      check("abort_pre_mem_write", 203, {31'd0, mem_write}, 32'd1);
      check("abort_pre_state", 203, {28'd0, state}, 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_async_mem_write", 204, {31'd0, mem_write}, 32'd0);
      check("abort_async_ctl", 204, {14'd0, ctl_word}, {14'd0, W_IDLE});
      check("abort_async_state", 204, {28'd0, state}, 32'd0);
      @(posedge clk); #1;
      run_vec('{1'b0, OP_SW, 1'b1, 4'd0, W_IDLE}, 205);
      run_vec('{1'b1, OP_SW, 1'b1, 4'd0, W_IDLE}, 206);
      run_vec('{1'b1, OP_SW, 1'b1, 4'd0, W_FETCH_R}, 207);
      run_vec('{1'b1, OP_SW, 1'b1, 4'd1, W_DECODE}, 208);
      run_vec('{1'b1, OP_SW, 1'b1, 4'd2, W_ADR}, 209);
      check("done_count_aborted", 210, n_done, 6);
      run_vec('{1'b1, OP_SW, 1'b1, 4'd5, W_MEMWR_R}, 211);
      run_vec('{1'b1, OP_SW, 1'b0, 4'd0, W_FETCH_W}, 212);
      check("done_count_total", 213, n_done, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mc_control.md
# mc_control

Main control unit of the multi-cycle CPU. A Moore-style finite state machine sequences one instruction over 3–5+ cycles. Each cycle it drives the multiplexer selects, register write enables and memory strobes for the shared datapath: PC, IR, MDR, A/B, ALU and the address register. It decodes the IR opcode field once per instruction and stalls on a memory-ready handshake, so slow memories insert wait states without datapath changes.

## Interface
Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  6  IR[31:26], stable from DECODE onward
- mem_ready  input  1  memory completes the current access this cycle
- pc_write, pc_write_cond  output  1 each  unconditional PC load / PC load qualified by ALU zero
- iord  output  1  memory address source: 0 = PC, 1 = address register
- mem_read, mem_write  output  1 each  memory strobes
- ir_write  output  1  IR load enable
- mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A operand: 0 = PC, 1 = A
- alu_src_b  output  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = use funct field
- pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse on the final cycle of each legal instruction
- illegal_op  output  1  one-cycle pulse in DECODE for an unrecognised opcode
- state  output  4  current state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 are unreachable; if ever entered, the next state is FETCH with all outputs 0.
- Outputs not listed for a state are 0.
- FETCH: mem_read=1, alu_src_b=01. ir_write=pc_write=mem_ready. Advance to DECODE when mem_ready=1, otherwise hold.
- DECODE: alu_src_b=11. Next state by opcode:
  - LW/SW → MEMADR
  - RTYPE → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDIEX
  - any other opcode → FETCH, with illegal_op=1
- MEMADR: alu_src_a=1, alu_src_b=10. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, iord=1. Advance to MEMWB on mem_ready, otherwise hold.
- MEMWB: reg_write=1, mem_to_reg=1, instr_done=1. Next state FETCH.
- MEMWR: mem_write=1, iord=1. instr_done=mem_ready. Advance to FETCH on mem_ready, otherwise hold.
- EXEC: alu_src_a=1, alu_op=10. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10. Next state ADDIWB.
- ADDIWB: reg_write=1, instr_done=1. Next state FETCH.
- Run flag: a registered `run` bit is reset to 0 and set to 1 on the first clock edge after rst_n is released.
  - While run=0, every output except `state` is forced to 0 and the state machine does not advance.

## Timing
- Reset (rst_n low): state=FETCH, run=0, and all outputs are 0 asynchronously. `state` reads 0.
- First edge after release: run is set to 1. FETCH outputs become active in the cycle after that edge.
- Cycle counts with mem_ready held at 1:
  - RTYPE 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4
  - illegal opcode: 2 (FETCH, DECODE), then back to FETCH
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
  - Strobes stay asserted and addresses stay stable during the wait.
  - ir_write, pc_write and instr_done stay 0 during the wait.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- opcode is sampled only in DECODE and MEMADR.
- Reset asserted mid-instruction aborts it immediately: no partial write strobe survives past the reset edge, and execution resumes at FETCH.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. Required: all outputs 0 during reset and for 1 cycle after release; mem_read=1 with state=0 on the next cycle.
- LW with 2 fetch and 3 read wait states:
  - state sequence 0,0,0,1,2,3,3,3,3,4
  - ir_write high only on the third FETCH cycle
  - reg_write=mem_to_reg=1 only in state 4
  - total 10 cycles
- R-type back-to-back with ADDI, mem_ready=1:
  - states 0,1,6,7,0,1,10,11
  - instr_done high in cycles 4 and 8 only
  - reg_dst=1 in state 7, 0 in state 11
- BEQ then J:
  - states 0,1,8,0,1,9
  - pc_write_cond=1, pc_source=01 in state 8
  - pc_write=1, pc_source=10 in state 9
- Illegal opcode 6'b111111: states 0,1,0. illegal_op=1 for exactly the DECODE cycle; instr_done stays 0.
- SW with rst_n pulsed low during MEMWR while mem_ready=0:
  - mem_write drops asynchronously on reset
  - after release, sequence restarts at FETCH with the 1 idle cycle
  - no instr_done is emitted for the aborted store
